mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Ports SHALL be:
- clk  in  1  sole clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction-fetch read request
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables
- data_addr  in  32  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  load/store request accepted this cycle
- data_data_ok  out  1  load data valid / store complete this cycle
- data_rdata  out  32  load data
- mem_req  out  1  request to the shared memory port
- mem_wr  out  1  forwarded write flag (0 for fetches)
- mem_wstrb  out  4  forwarded byte enables (0 for fetches)
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded store data (0 for fetches)
- mem_addr_ok  in  1  memory accepted the request
- mem_data_ok  in  1  memory returns data / write acknowledge, in request order
- mem_rdata  in  32  memory read data
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 Handshake: a request transfers on any cycle where mem_req=1 and mem_addr_ok=1.
REQ-004 Grant when unlocked: data has priority over inst if both req=1; otherwise the single requester wins.
REQ-005 Grant lock: if mem_req=1 and mem_addr_ok=0, the granted source SHALL be held on the next cycle regardless of the other requester, until a transfer occurs.
REQ-006 Lock release:
- the lock SHALL clear on transfer
- if the locked source drops req, the lock SHALL clear and arbitration restarts the same cycle.
REQ-007 mem_req = (inst_req | data_req) & ~fifo_full.
REQ-008 mem_wr/mem_wstrb/mem_addr/mem_wdata SHALL be taken combinationally from the granted source.
REQ-009 Accept routing: the granted source's addr_ok SHALL equal mem_addr_ok & mem_req; the other source's addr_ok SHALL be 0.
REQ-010 Owner FIFO: 4 entries of 1 bit (0 = inst, 1 = data), 3-bit count 0..4; each transfer pushes the owner.
REQ-011 Response routing: on mem_data_ok=1 with count>0, only the head owner's data_ok SHALL be 1, then the head pops.
REQ-012 inst_rdata and data_rdata SHALL both equal mem_rdata at all times.
REQ-013 Simultaneous push and pop: count SHALL be unchanged and pointers SHALL both advance modulo 4.
REQ-014 Full: at count=4, mem_req=0 and both addr_ok=0, even if mem_data_ok=1 in the same cycle; acceptance resumes the next cycle.
REQ-015 mem_data_ok at count=0 SHALL be ignored: both data_ok=0, no state change.
REQ-016 Latency: request to mem_req and mem_data_ok to data_ok SHALL be 0 cycles (combinational); throughput is one transfer per cycle.

Reset
REQ-017 While reset=1, at the next posedge: count=0, pointers=0, lock cleared; mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok SHALL be 0 throughout reset.
REQ-018 Reset mid-operation SHALL discard all outstanding owners; responses arriving after reset SHALL be ignored per REQ-015.

Verification
REQ-019 Both req=1 with mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr, count becomes 1.
REQ-020 Only inst_req=1 with mem_addr_ok=0 for 3 cycles, data_req rising in cycle 2 -> mem_addr stays inst_addr; on the 4th cycle with mem_addr_ok=1 -> inst_addr_ok=1; data is granted the next cycle.
REQ-021 Push inst, data, inst (count=3), then three mem_data_ok pulses with rdata 0x11, 0x22, 0x33 -> inst_data_ok, data_data_ok, inst_data_ok in order; count returns to 0.
REQ-022 Four accepted requests with no response -> count=4, mem_req=0; one mem_data_ok -> count=3, mem_req asserts the next cycle.
REQ-023 Store data_wr=1, wstrb=0xF, wdata=0xDEADBEEF accepted -> mem_wr=1, mem_wdata=0xDEADBEEF; mem_data_ok later -> data_data_ok=1.
REQ-024 Reset asserted at count=2, then mem_data_ok=1 after reset -> no data_ok asserted, count=0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-source (instruction fetch / load-store) arbiter onto one in-order memory port.
// Grants are held while the memory stalls, and a 4-entry owner FIFO routes responses back.
module mem_req_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic [DATA_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [3:0]        data_wstrb,
   input  logic [DATA_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [3:0]        mem_wstrb,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic       lock_q, lock_d;
   logic       lock_src_q, lock_src_d;
   logic [3:0] owner_q, owner_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;

   logic grant_data;
   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic head_owner;

   always_comb begin
      fifo_full  = (count_q == 3'd4);
      fifo_empty = (count_q == 3'd0);

      // A held grant only survives while its own source keeps requesting.
      if (lock_q && (lock_src_q ? data_req : inst_req)) begin
         grant_data = lock_src_q;
      end else begin
         grant_data = data_req;
      end

      mem_req   = (inst_req | data_req) & ~fifo_full & ~reset;
      mem_wr    = grant_data & data_wr;
      mem_wstrb = grant_data ? data_wstrb : 4'h0;
      mem_addr  = grant_data ? data_addr : inst_addr;
      mem_wdata = grant_data ? data_wdata : '0;

      push         = mem_req & mem_addr_ok;
      data_addr_ok = push & grant_data;
      inst_addr_ok = push & ~grant_data;

      pop          = mem_data_ok & ~fifo_empty & ~reset;
      head_owner   = owner_q[rd_ptr_q];
      data_data_ok = pop & head_owner;
      inst_data_ok = pop & ~head_owner;

      inst_rdata = mem_rdata;
      data_rdata = mem_rdata;

      owner_d = owner_q;
      if (push) begin
         owner_d[wr_ptr_q] = grant_data;
      end
      wr_ptr_d = wr_ptr_q + 2'(push);
      rd_ptr_d = rd_ptr_q + 2'(pop);
      count_d  = count_q + 3'(push) - 3'(pop);

      lock_d     = mem_req & ~mem_addr_ok;
      lock_src_d = grant_data;
   end

   // Owner bits and held source carry no meaning once count/lock are cleared.
   always_ff @(posedge clk) begin
      owner_q    <= owner_d;
      lock_src_q <= lock_src_d;
      if (reset) begin
         lock_q   <= 1'b0;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         lock_q   <= lock_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, data_req, data_wr;
   logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
   logic [3:0]  data_wstrb;
   logic        mem_addr_ok, mem_data_ok;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
   logic        mem_req, mem_wr;
   logic [3:0]  mem_wstrb;

   mem_req_arbiter #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outstanding owners as a queue, held source as -1/0/1.
   bit own[$];
   int held = -1;
   bit started = 0;

   function automatic int model_src();
      if (held == 1 && data_req) return 1;
      if (held == 0 && inst_req) return 0;
      return data_req ? 1 : 0;
   endfunction

   function automatic bit model_mem_req();
      return (inst_req || data_req) && own.size() < 4 && !reset;
   endfunction

   always @(posedge clk) begin
      int  s;
      bit  mr;
      s  = model_src();
      mr = model_mem_req();
      if (reset) begin
         own.delete();
         held = -1;
      end else begin
         if (mem_data_ok && own.size() > 0) void'(own.pop_front());
         if (mr && mem_addr_ok) own.push_back(s[0]);
         held = (mr && !mem_addr_ok) ? s : -1;
      end
      started = 1;
   end

   always @(negedge clk) begin
      int  s;
      bit  mr, pop, hd;
      if (started) begin
         s   = model_src();
         mr  = model_mem_req();
         pop = mem_data_ok && own.size() > 0 && !reset;
         hd  = (own.size() > 0) ? own[0] : 1'b0;
         chk("m_mem_req", mem_req, mr);
         chk("m_mem_addr", mem_addr, s ? data_addr : inst_addr);
         chk("m_mem_wr", mem_wr, s ? data_wr : 1'b0);
         chk("m_mem_wstrb", mem_wstrb, s ? data_wstrb : 4'h0);
         chk("m_mem_wdata", mem_wdata, s ? data_wdata : 32'h0);
         chk("m_inst_addr_ok", inst_addr_ok, mr && mem_addr_ok && s == 0);
         chk("m_data_addr_ok", data_addr_ok, mr && mem_addr_ok && s == 1);
         chk("m_inst_data_ok", inst_data_ok, pop && !hd);
         chk("m_data_data_ok", data_data_ok, pop && hd);
         chk("m_inst_rdata", inst_rdata, mem_rdata);
         chk("m_data_rdata", data_rdata, mem_rdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = 4'h0;
      inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
      data_wdata = 32'h0; mem_rdata = 32'h0;
      mem_addr_ok = 0; mem_data_ok = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   initial begin
      reset = 1;
      idle();
      tick();
      // Outputs stay quiet during reset even with every input active.
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      @(negedge clk);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
      chk("rst_data_addr_ok", data_addr_ok, 1'b0);
      chk("rst_inst_data_ok", inst_data_ok, 1'b0);
      chk("rst_data_data_ok", data_data_ok, 1'b0);
      tick();

      // Both request: data wins.
      do_reset();
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      @(negedge clk);
      chk("pri_data_addr_ok", data_addr_ok, 1'b1);
      chk("pri_inst_addr_ok", inst_addr_ok, 1'b0);
      chk("pri_mem_addr", mem_addr, 32'h0000_2000);
      tick();
      idle(); mem_data_ok = 1; mem_rdata = 32'hAB;
      @(negedge clk);
      chk("pri_data_data_ok", data_data_ok, 1'b1);
      chk("pri_data_rdata", data_rdata, 32'hAB);
      tick();
      mem_data_ok = 1;
      @(negedge clk);
      chk("pri_empty_ignored", data_data_ok, 1'b0);
      tick();

      // Stalled inst grant is held when data starts requesting.
      do_reset();
      inst_req = 1;
      @(negedge clk);
      chk("lock_c1_addr", mem_addr, 32'h0000_1000);
      tick();
      data_req = 1;
      @(negedge clk);
      chk("lock_c2_addr", mem_addr, 32'h0000_1000);
      tick();
      @(negedge clk);
      chk("lock_c3_addr", mem_addr, 32'h0000_1000);
      tick();
      mem_addr_ok = 1;
      @(negedge clk);
      chk("lock_c4_inst_ok", inst_addr_ok, 1'b1);
      chk("lock_c4_data_ok", data_addr_ok, 1'b0);
      tick();
      @(negedge clk);
      chk("lock_c5_data_ok", data_addr_ok, 1'b1);
      chk("lock_c5_addr", mem_addr, 32'h0000_2000);
      tick();

      // In-order response routing inst, data, inst.
      do_reset();
      mem_addr_ok = 1;
      inst_req = 1; tick();
      inst_req = 0; data_req = 1; tick();
      data_req = 0; inst_req = 1; tick();
      idle(); mem_data_ok = 1; mem_rdata = 32'h11;
      @(negedge clk);
      chk("ord1_inst", inst_data_ok, 1'b1);
      chk("ord1_data", data_data_ok, 1'b0);
      chk("ord1_rdata", inst_rdata, 32'h11);
      tick();
      mem_rdata = 32'h22;
      @(negedge clk);
      chk("ord2_inst", inst_data_ok, 1'b0);
      chk("ord2_data", data_data_ok, 1'b1);
      tick();
      mem_rdata = 32'h33;
      @(negedge clk);
      chk("ord3_inst", inst_data_ok, 1'b1);
      tick();
      @(negedge clk);
      chk("ord4_inst", inst_data_ok, 1'b0);
      chk("ord4_data", data_data_ok, 1'b0);
      tick();

      // Fill to four outstanding, then drain one.
      do_reset();
      inst_req = 1; mem_addr_ok = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("fill_inst_ok", inst_addr_ok, 1'b1);
         tick();
      end
      @(negedge clk);
      chk("full_mem_req", mem_req, 1'b0);
      chk("full_inst_ok", inst_addr_ok, 1'b0);
      tick();
      mem_data_ok = 1;
      @(negedge clk);
      chk("full_pop_mem_req", mem_req, 1'b0);
      chk("full_pop_inst_ok", inst_addr_ok, 1'b0);
      chk("full_pop_data_ok", inst_data_ok, 1'b1);
      tick();
      mem_data_ok = 0;
      @(negedge clk);
      chk("after_pop_mem_req", mem_req, 1'b1);
      tick();

      // Store forwarding.
      do_reset();
      data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF;
      data_addr = 32'h0000_0040; mem_addr_ok = 1;
      @(negedge clk);
      chk("st_mem_wr", mem_wr, 1'b1);
      chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("st_mem_wstrb", mem_wstrb, 4'hF);
      chk("st_data_addr_ok", data_addr_ok, 1'b1);
      tick();
      idle(); tick();
      mem_data_ok = 1;
      @(negedge clk);
      chk("st_data_data_ok", data_data_ok, 1'b1);
      tick();

      // Reset discards outstanding owners.
      do_reset();
      inst_req = 1; mem_addr_ok = 1; tick(); tick();
      idle(); reset = 1;
      @(negedge clk);
      chk("rst_mid_mem_req", mem_req, 1'b0);
      tick();
      reset = 0; mem_data_ok = 1;
      @(negedge clk);
      chk("rst_mid_inst_data_ok", inst_data_ok, 1'b0);
      chk("rst_mid_data_data_ok", data_data_ok, 1'b0);
      tick();

      // Randomized traffic; the per-cycle model compare does the checking.
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 199) == 0);
         inst_req    = ($urandom_range(0, 99) < 60);
         data_req    = ($urandom_range(0, 99) < 50);
         data_wr     = $urandom_range(0, 1);
         data_wstrb  = 4'($urandom);
         inst_addr   = $urandom;
         data_addr   = $urandom;
         data_wdata  = $urandom;
         mem_rdata   = $urandom;
         mem_addr_ok = ($urandom_range(0, 99) < 55);
         mem_data_ok = ($urandom_range(0, 99) < 45);
         tick();
      end

      idle();
      reset = 0;
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
